ex_mdu: RTL

Multi-cycle RV32M multiply/divide unit sitting beside the combinational execute stage; the EX stage routes OP-type instructions with funct7 = 0000001 here instead of the single-cycle ALU. It runs an iterative shift-add multiplier and a restoring divider, parametrised in data width and bits retired per cycle. It holds the pipeline through a stall output to ctrl and returns one result with its destination register for the EX/MEM register. A flush from ctrl aborts any operation in flight.

---
 rtl/ex_mdu_pkg.sv | 43 ++++
 rtl/ex_mdu_step.sv | 73 +++++++
 rtl/ex_mdu.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// the OP-type funct7 that routes an instruction here, the FSM state
// encoding and small operand-signedness helpers.
package ex_mdu_pkg;

    // funct7 of OP-type instructions that belong to the M extension
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // RV32M funct3 codes
    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    // Unit state encoding
    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_t;

    // rs1 is treated as two's complement for these ops
    function automatic logic op1_is_signed(input logic [2:0] f3);
        case (f3)
            INST_MULH, INST_MULHSU, INST_DIV, INST_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // rs2 is treated as two's complement for these ops (MULHSU: rs2 unsigned)
    function automatic logic op2_is_signed(input logic [2:0] f3);
        case (f3)
            INST_MULH, INST_DIV, INST_REM: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mdu_step.sv
// One combinational iteration of the MDU datapath.
// Multiply: add the multiplicand to the high half when the multiplier LSB is
// set, then shift the {high, low} pair right by one.
// Divide (restoring): shift the next dividend bit into the remainder, subtract
// the divisor if it fits and shift the resulting quotient bit into low.
// DIV_EN = 0 removes the subtract-shift path entirely.
module ex_mdu_step
    import ex_mdu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic            div_mode,
    input  logic [XLEN:0]   a_in,   // product high half / remainder
    input  logic [XLEN-1:0] b_in,   // multiplier / dividend-quotient
    input  logic [XLEN-1:0] m,      // multiplicand / divisor
    output logic [XLEN:0]   a_out,
    output logic [XLEN-1:0] b_out
);

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   mul_a;
    logic [XLEN-1:0] mul_b;

    // Conditional add followed by a one-bit right shift of the accumulator
    always_comb begin
        if (b_in[0]) begin
            mul_sum = a_in + {1'b0, m};
        end else begin
            mul_sum = a_in;
        end
        mul_a = {1'b0, mul_sum[XLEN:1]};
        mul_b = {mul_sum[0], b_in[XLEN-1:1]};
    end

    generate
        if (DIV_EN) begin : g_div
            logic [XLEN:0] shifted;
            logic [XLEN:0] diff;
            logic          fits;

            // Restoring divide step: trial subtract, keep it only if it fits
            always_comb begin
                shifted = {a_in[XLEN-1:0], b_in[XLEN-1]};
                diff    = shifted - {1'b0, m};
                fits    = (shifted >= {1'b0, m});
                if (div_mode) begin
                    if (fits) begin
                        a_out = diff;
                    end else begin
                        a_out = shifted;
                    end
                    b_out = {b_in[XLEN-2:0], fits};
                end else begin
                    a_out = mul_a;
                    b_out = mul_b;
                end
            end
        end else begin : g_nodiv
            // No divider: a divide op never reaches CALC; zero the path anyway
            always_comb begin
                if (div_mode) begin
                    a_out = {(XLEN+1){1'b0}};
                    b_out = {XLEN{1'b0}};
                end else begin
                    a_out = mul_a;
                    b_out = mul_b;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle RV32M multiply/divide unit beside the EX stage.
// Iterative shift-add multiplier and restoring divider retiring
// BITS_PER_CYCLE bits per CALC cycle; stalls the pipeline while working and
// returns one registered result with its destination register.
// Build option: define MDU_DIV_EN to include the divider (all eight ops);
// without it divide ops complete immediately with result 0 and no write.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      reg_w_addr_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      reg_w_addr_o,
    output logic            reg_w_ena_o
);

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int            N      = XLEN / BITS_PER_CYCLE;
    localparam int            CW     = $clog2(N + 1);
    localparam logic [CW-1:0] N_INIT = CW'(N);

    mdu_state_t      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      funct3_q;
    logic            s1_q;
    logic            s2_q;
    logic [XLEN:0]   acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] mcand;

    // Capture-side decode of the incoming operands
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            div_ovf;

    // Sign flags, magnitudes and the two divide short-cut conditions
    always_comb begin
        s1 = op1_is_signed(funct3_i) & op1_i[XLEN-1];
        s2 = op2_is_signed(funct3_i) & op2_i[XLEN-1];
        if (s1) begin
            mag1 = -op1_i;
        end else begin
            mag1 = op1_i;
        end
        if (s2) begin
            mag2 = -op2_i;
        end else begin
            mag2 = op2_i;
        end
        div_zero = funct3_i[2] & (op2_i == {XLEN{1'b0}});
        div_ovf  = funct3_i[2] & ~funct3_i[0]
                 & (op1_i == {1'b1, {(XLEN-1){1'b0}}})
                 & (op2_i == {XLEN{1'b1}});
    end

    // Iteration chain: BITS_PER_CYCLE steps evaluated back to back per cycle
    logic [XLEN:0]   a_chain [0:BITS_PER_CYCLE];
    logic [XLEN-1:0] b_chain [0:BITS_PER_CYCLE];

    assign a_chain[0] = acc_hi;
    assign b_chain[0] = acc_lo;

    generate
        for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
            ex_mdu_step #(
                .XLEN   (XLEN),
                .DIV_EN (DIV_EN)
            ) u_step (
                .div_mode (funct3_q[2]),
                .a_in     (a_chain[i]),
                .b_in     (b_chain[i]),
                .m        (mcand),
                .a_out    (a_chain[i+1]),
                .b_out    (b_chain[i+1])
            );
        end
    endgenerate

    // Sign correction and result selection applied in FIX
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;

    // Negate product/quotient on differing signs; remainder follows dividend
    always_comb begin
        prod = {acc_hi[XLEN-1:0], acc_lo};
        if (s1_q ^ s2_q) begin
            prod_s = -prod;
            quo_s  = -acc_lo;
        end else begin
            prod_s = prod;
            quo_s  = acc_lo;
        end
        if (s1_q) begin
            rem_s = -acc_hi[XLEN-1:0];
        end else begin
            rem_s = acc_hi[XLEN-1:0];
        end
        case (funct3_q)
            INST_MUL:                           fix_res = prod_s[XLEN-1:0];
            INST_MULH, INST_MULHSU, INST_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            INST_DIV, INST_DIVU:                fix_res = quo_s;
            INST_REM, INST_REMU:                fix_res = rem_s;
            default:                            fix_res = {XLEN{1'b0}};
        endcase
    end

    // Hold the pipeline from acceptance until the result is presented
    assign stall_o = ((state == MDU_IDLE) & start_i & ~flush_i)
                   | (state == MDU_CALC) | (state == MDU_FIX);

    // Control FSM with operand capture, iteration and registered outputs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= MDU_IDLE;
            cnt          <= {CW{1'b0}};
            funct3_q     <= 3'b000;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            acc_hi       <= {(XLEN+1){1'b0}};
            acc_lo       <= {XLEN{1'b0}};
            mcand        <= {XLEN{1'b0}};
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            result_o     <= {XLEN{1'b0}};
            reg_w_addr_o <= 5'd0;
            reg_w_ena_o  <= 1'b0;
        end else if (flush_i) begin
            state       <= MDU_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            reg_w_ena_o <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    done_o      <= 1'b0;
                    reg_w_ena_o <= 1'b0;
                    if (start_i) begin
                        funct3_q     <= funct3_i;
                        s1_q         <= s1;
                        s2_q         <= s2;
                        reg_w_addr_o <= reg_w_addr_i;
                        busy_o       <= 1'b1;
                        cnt          <= N_INIT;
                        acc_hi       <= {(XLEN+1){1'b0}};
                        // Divide iterates the dividend; multiply the multiplier
                        acc_lo       <= funct3_i[2] ? mag1 : mag2;
                        mcand        <= funct3_i[2] ? mag2 : mag1;
                        if (funct3_i[2] && !DIV_EN) begin
                            state       <= MDU_DONE;
                            done_o      <= 1'b1;
                            result_o    <= {XLEN{1'b0}};
                            reg_w_ena_o <= 1'b0;
                        end else if (div_zero) begin
                            state       <= MDU_DONE;
                            done_o      <= 1'b1;
                            result_o    <= funct3_i[1] ? op1_i : {XLEN{1'b1}};
                            reg_w_ena_o <= (reg_w_addr_i != 5'd0);
                        end else if (div_ovf) begin
                            state       <= MDU_DONE;
                            done_o      <= 1'b1;
                            result_o    <= funct3_i[1] ? {XLEN{1'b0}} : op1_i;
                            reg_w_ena_o <= (reg_w_addr_i != 5'd0);
                        end else begin
                            state <= MDU_CALC;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                MDU_CALC: begin
                    acc_hi <= a_chain[BITS_PER_CYCLE];
                    acc_lo <= b_chain[BITS_PER_CYCLE];
                    cnt    <= cnt - CW'(1'b1);
                    if (cnt == CW'(1'b1)) begin
                        state <= MDU_FIX;
                    end else begin
                        state <= MDU_CALC;
                    end
                end
                MDU_FIX: begin
                    state       <= MDU_DONE;
                    done_o      <= 1'b1;
                    result_o    <= fix_res;
                    reg_w_ena_o <= (reg_w_addr_o != 5'd0);
                end
                MDU_DONE: begin
                    state       <= MDU_IDLE;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                    reg_w_ena_o <= 1'b0;
                end
                default: begin
                    state       <= MDU_IDLE;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                    reg_w_ena_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
